// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - fetch stage: owns PC, requests imem, holds instr until the next PC is chosen
// Optional FETCH_MISALIGN_TRAP_EN adds a misaligned output and a terminal TRAP state.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_valid,
    input  logic        stall,
    input  logic        PCSrc,
    input  logic [31:0] ImmExt,
    output logic [31:0] instr,
    output logic        instr_valid,
    output logic [31:0] PC,
`ifdef FETCH_MISALIGN_TRAP_EN
    output logic        misaligned,
`endif
    output logic [31:0] PCPlus4
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_FETCH = 2'd1;
    localparam logic [1:0] ST_HOLD  = 2'd2;
`ifdef FETCH_MISALIGN_TRAP_EN
    localparam logic [1:0] ST_TRAP  = 2'd3;
`endif

    logic [1:0]  state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic        instr_valid_q, instr_valid_d;
    logic [31:0] target;
`ifdef FETCH_MISALIGN_TRAP_EN
    logic        misaligned_q, misaligned_d;
`endif

    assign target = PCSrc ? (pc_q + ImmExt) : (pc_q + 32'd4);

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        instr_d       = instr_q;
        instr_valid_d = instr_valid_q;
`ifdef FETCH_MISALIGN_TRAP_EN
        misaligned_d  = misaligned_q;
`endif
        case (state_q)
            ST_IDLE: state_d = ST_FETCH;
            ST_FETCH: begin
                if (imem_valid) begin
                    instr_d       = imem_rdata;
                    instr_valid_d = 1'b1;
                    state_d       = ST_HOLD;
                end
            end
            ST_HOLD: begin
                // PCSrc/ImmExt only matter on the edge that releases the held instruction
                if (!stall) begin
                    instr_d       = NOP_INSTR;
                    instr_valid_d = 1'b0;
                    state_d       = ST_FETCH;
                    pc_d          = target & ~32'd3;
`ifdef FETCH_MISALIGN_TRAP_EN
                    if (PCSrc && target[1]) begin
                        pc_d         = target;
                        misaligned_d = 1'b1;
                        state_d      = ST_TRAP;
                    end
`endif
                end
            end
`ifdef FETCH_MISALIGN_TRAP_EN
            ST_TRAP: state_d = ST_TRAP;
`endif
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            pc_q          <= RESET_PC;
            instr_q       <= NOP_INSTR;
            instr_valid_q <= 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
            misaligned_q  <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            instr_q       <= instr_d;
            instr_valid_q <= instr_valid_d;
`ifdef FETCH_MISALIGN_TRAP_EN
            misaligned_q  <= misaligned_d;
`endif
        end
    end

    assign imem_req    = (state_q == ST_FETCH);
    assign imem_addr   = pc_q;
    assign instr       = instr_q;
    assign instr_valid = instr_valid_q;
    assign PC          = pc_q;
    assign PCPlus4     = pc_q + 32'd4;
`ifdef FETCH_MISALIGN_TRAP_EN
    assign misaligned  = misaligned_q;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb/tb_instr_fetch_unit.sv - self-checking bench for instr_fetch_unit (directed scenarios plus randomized run vs a transaction model)
module tb_instr_fetch_unit;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata = 32'd0;
    logic        imem_valid = 1'b0;
    logic        stall = 1'b0;
    logic        PCSrc = 1'b0;
    logic [31:0] ImmExt = 32'd0;
    logic [31:0] instr;
    logic        instr_valid;
    logic [31:0] PC;
    logic [31:0] PCPlus4;
`ifdef FETCH_MISALIGN_TRAP_EN
    logic        misaligned;
`endif

    int errors = 0;
    int checks = 0;
    logic [31:0] held_word;

    instr_fetch_unit dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_rdata (imem_rdata),
        .imem_valid (imem_valid),
        .stall      (stall),
        .PCSrc      (PCSrc),
        .ImmExt     (ImmExt),
        .instr      (instr),
        .instr_valid(instr_valid),
        .PC         (PC),
`ifdef FETCH_MISALIGN_TRAP_EN
        .misaligned (misaligned),
`endif
        .PCPlus4    (PCPlus4)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        step();
        step();
        checks++;
        if ({imem_req, instr_valid, instr, PC, PCPlus4} !== {1'b0, 1'b0, NOP, 32'd0, 32'd4}) begin
            errors++;
            $display("FAIL reset_state: req=%0b valid=%0b instr=%h PC=%h PCPlus4=%h, required 0 0 %h 0 4",
                     imem_req, instr_valid, instr, PC, PCPlus4, NOP);
        end
`ifdef FETCH_MISALIGN_TRAP_EN
        checks++;
        if (misaligned !== 1'b0) begin
            errors++;
            $display("FAIL reset_misaligned: got %0b, required 0", misaligned);
        end
`endif
    endtask

    task automatic test_basic();
        imem_valid = 1'b1;
        imem_rdata = 32'h0050_0093;
        stall = 1'b0;
        PCSrc = 1'b0;
        rst_n = 1'b1;
        step();
        checks++;
        if ({imem_req, imem_addr, instr_valid} !== {1'b1, 32'd0, 1'b0}) begin
            errors++;
            $display("FAIL first_req: req=%0b addr=%h valid=%0b, required 1 0 0", imem_req, imem_addr, instr_valid);
        end
        step();
        checks++;
        if ({instr, instr_valid, imem_req, PC} !== {32'h0050_0093, 1'b1, 1'b0, 32'd0}) begin
            errors++;
            $display("FAIL first_capture: instr=%h valid=%0b req=%0b PC=%h, required 00500093 1 0 0",
                     instr, instr_valid, imem_req, PC);
        end
        step();
        checks++;
        if ({imem_req, imem_addr, instr_valid, instr} !== {1'b1, 32'd4, 1'b0, NOP}) begin
            errors++;
            $display("FAIL second_fetch: req=%0b addr=%h valid=%0b instr=%h, required 1 4 0 %h",
                     imem_req, imem_addr, instr_valid, instr, NOP);
        end
    endtask

    task automatic test_branch();
        step();
        PCSrc = 1'b1;
        ImmExt = 32'h0000_00FC;
        step();
        checks++;
        if (imem_addr !== 32'h100) begin
            errors++;
            $display("FAIL branch_fwd: addr=%h, required 00000100", imem_addr);
        end
        step();
        ImmExt = 32'hFFFF_FFF0;
        step();
        checks++;
        if ({imem_req, imem_addr, PC, PCPlus4} !== {1'b1, 32'h0F0, 32'h0F0, 32'h0F4}) begin
            errors++;
            $display("FAIL branch_back: req=%0b addr=%h PC=%h PCPlus4=%h, required 1 f0 f0 f4",
                     imem_req, imem_addr, PC, PCPlus4);
        end
        PCSrc = 1'b0;
    endtask

    task automatic test_wait_states();
        held_word = $urandom;
        imem_rdata = held_word;
        for (int i = 0; i < 4; i++) begin
            imem_valid = (i == 3);
            checks++;
            if ({imem_req, imem_addr, instr_valid, instr} !== {1'b1, 32'h0F0, 1'b0, NOP}) begin
                errors++;
                $display("FAIL wait_state_%0d: req=%0b addr=%h valid=%0b instr=%h, required 1 f0 0 %h",
                         i, imem_req, imem_addr, instr_valid, instr, NOP);
            end
            step();
        end
        checks++;
        if ({instr, instr_valid, imem_req} !== {held_word, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL wait_capture: instr=%h valid=%0b req=%0b, required %h 1 0",
                     instr, instr_valid, imem_req, held_word);
        end
    endtask

    task automatic test_stall();
        stall = 1'b1;
        imem_valid = 1'b1;
        imem_rdata = ~held_word;
        for (int i = 0; i < 5; i++) begin
            PCSrc = i[0];
            ImmExt = $urandom;
            step();
            checks++;
            if ({instr, PC, instr_valid, imem_req} !== {held_word, 32'h0F0, 1'b1, 1'b0}) begin
                errors++;
                $display("FAIL stall_hold_%0d: instr=%h PC=%h valid=%0b req=%0b, required %h f0 1 0",
                         i, instr, PC, instr_valid, imem_req, held_word);
            end
        end
        stall = 1'b0;
        PCSrc = 1'b0;
        step();
        checks++;
        if ({PC, imem_req} !== {32'h0F4, 1'b1}) begin
            errors++;
            $display("FAIL stall_release: PC=%h req=%0b, required f4 1", PC, imem_req);
        end
    endtask

    task automatic test_wrap();
        imem_valid = 1'b1;
        step();
        PCSrc = 1'b1;
        ImmExt = 32'hFFFF_FF08;
        step();
        checks++;
        if ({PC, PCPlus4} !== {32'hFFFF_FFFC, 32'h0}) begin
            errors++;
            $display("FAIL wrap_top: PC=%h PCPlus4=%h, required fffffffc 0", PC, PCPlus4);
        end
        step();
        PCSrc = 1'b0;
        step();
        checks++;
        if ({PC, PCPlus4, imem_addr} !== {32'h0, 32'h4, 32'h0}) begin
            errors++;
            $display("FAIL wrap_zero: PC=%h PCPlus4=%h addr=%h, required 0 4 0", PC, PCPlus4, imem_addr);
        end
    endtask

    // Transaction view: a fetch is pending until a word arrives; a held word
    // retires on any unstalled edge and picks the next aligned address.
    task automatic test_random();
        logic [31:0] m_pc = 32'h0;
        logic [31:0] m_instr = NOP;
        logic        m_have = 1'b0;
        for (int n = 0; n < 300; n++) begin
            imem_valid = ($urandom_range(0, 2) != 0);
            imem_rdata = $urandom;
            stall = ($urandom_range(0, 3) == 0);
            PCSrc = $urandom_range(0, 1);
`ifdef FETCH_MISALIGN_TRAP_EN
            ImmExt = $urandom & 32'hFFFF_FFFC;
`else
            ImmExt = $urandom;
`endif
            if (!m_have) begin
                if (imem_valid) begin
                    m_instr = imem_rdata;
                    m_have = 1'b1;
                end
            end else if (!stall) begin
                m_pc = (PCSrc ? m_pc + ImmExt : m_pc + 32'd4) & 32'hFFFF_FFFC;
                m_have = 1'b0;
                m_instr = NOP;
            end
            step();
            checks++;
            if ({instr, instr_valid, PC, PCPlus4, imem_req, imem_addr} !==
                {m_instr, m_have, m_pc, m_pc + 32'd4, ~m_have, m_pc}) begin
                errors++;
                $display("FAIL random_%0d: instr=%h valid=%0b PC=%h PCPlus4=%h req=%0b addr=%h, required %h %0b %h %h %0b %h",
                         n, instr, instr_valid, PC, PCPlus4, imem_req, imem_addr,
                         m_instr, m_have, m_pc, m_pc + 32'd4, ~m_have, m_pc);
            end
        end
    endtask

    task automatic test_reset_mid_fetch();
        int budget = 0;
        imem_valid = 1'b0;
        stall = 1'b0;
        PCSrc = 1'b0;
        while (imem_req !== 1'b1 && budget < 10) begin
            step();
            budget++;
        end
        checks++;
        if (imem_req !== 1'b1) begin
            errors++;
            $display("FAIL reach_fetch: req=%0b after %0d cycles, required 1", imem_req, budget);
        end
        imem_valid = 1'b1;
        imem_rdata = $urandom;
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({instr, instr_valid, PC, imem_req} !== {NOP, 1'b0, 32'd0, 1'b0}) begin
            errors++;
            $display("FAIL async_reset: instr=%h valid=%0b PC=%h req=%0b, required %h 0 0 0",
                     instr, instr_valid, PC, imem_req, NOP);
        end
        step();
        checks++;
        if ({instr, instr_valid, imem_req} !== {NOP, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset_held: instr=%h valid=%0b req=%0b, required %h 0 0", instr, instr_valid, imem_req, NOP);
        end
        rst_n = 1'b1;
        step();
        checks++;
        if ({imem_req, imem_addr} !== {1'b1, 32'd0}) begin
            errors++;
            $display("FAIL restart_fetch: req=%0b addr=%h, required 1 0", imem_req, imem_addr);
        end
    endtask

`ifdef FETCH_MISALIGN_TRAP_EN
    task automatic test_misaligned();
        imem_valid = 1'b1;
        step();
        PCSrc = 1'b1;
        ImmExt = 32'h0000_0102;
        for (int i = 0; i < 4; i++) begin
            step();
            checks++;
            if ({misaligned, PC, imem_req, instr_valid} !== {1'b1, 32'h102, 1'b0, 1'b0}) begin
                errors++;
                $display("FAIL misaligned_trap_%0d: mis=%0b PC=%h req=%0b valid=%0b, required 1 102 0 0",
                         i, misaligned, PC, imem_req, instr_valid);
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_branch();
        test_wait_states();
        test_stall();
        test_wrap();
        test_random();
        test_reset_mid_fetch();
`ifdef FETCH_MISALIGN_TRAP_EN
        test_misaligned();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
